// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared types and constants for the ALU request scheduler
package alu_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_e;

    // Captured ALU status, packed in rsp_flags bit order {ERR,OFLOW,COUT,G,L,E}
    typedef struct packed {
        logic err;
        logic oflow;
        logic cout;
        logic g;
        logic l;
        logic e;
    } alu_flags_t;

    localparam logic [3:0] CMD_MUL_INC = 4'd9;
    localparam logic [3:0] CMD_MUL_SHL = 4'd10;

    // Multiply commands take the longer ALU latency
    function automatic logic is_mul(input logic mode, input logic [3:0] cmd);
        return mode && ((cmd == CMD_MUL_INC) || (cmd == CMD_MUL_SHL));
    endfunction

endpackage

// File: rtl/alu_req_scheduler_rr_arbiter.sv
// rtl/alu_req_scheduler_rr_arbiter.sv - combinational round-robin priority search
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 any
);

    localparam int PW = $clog2(N);

    // Scan from the farthest offset back to ptr so the nearest request at or after ptr wins
    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                grant_idx = PW'(j);
                any       = 1'b1;
            end
        end
        grant = '0;
        if (any) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// rtl/alu_req_scheduler.sv - round-robin sharing of one ALU between several requesters
module alu_req_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ALU_LAT = 1,
    parameter int MUL_LAT = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_mode,
    input  logic [NUM_REQ*4-1:0]          req_cmd,
    input  logic [NUM_REQ*2-1:0]          req_inp_vld,
    input  logic [NUM_REQ-1:0]            req_cin,
    input  logic [NUM_REQ*DATA_W-1:0]     req_opa,
    input  logic [NUM_REQ*DATA_W-1:0]     req_opb,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [DATA_W:0]               rsp_res,
    output logic [5:0]                    rsp_flags,
    output logic                          alu_ce,
    output logic [1:0]                    alu_inp_vld,
    output logic                          alu_mode,
    output logic [3:0]                    alu_cmd,
    output logic                          alu_cin,
    output logic [DATA_W-1:0]             alu_opa,
    output logic [DATA_W-1:0]             alu_opb,
    input  logic [DATA_W:0]               alu_res,
    input  logic                          alu_err,
    input  logic                          alu_oflow,
    input  logic                          alu_cout,
    input  logic                          alu_g,
    input  logic                          alu_l,
    input  logic                          alu_e
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int LAT_W = 8;

    sched_state_e         state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;
    logic                 mode_q, mode_d;
    logic                 cin_q, cin_d;
    logic [3:0]           cmd_q, cmd_d;
    logic [1:0]           inp_q, inp_d;
    logic [DATA_W-1:0]    opa_q, opa_d;
    logic [DATA_W-1:0]    opb_q, opb_d;
    logic [DATA_W:0]      res_q, res_d;
    alu_flags_t           flags_q, flags_d;

    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      grant_idx;
    logic                 grant_any;
    logic [NUM_REQ-1:0]   req_ready_c;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // State, request latch and response registers; reset aborts any op in flight
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            lat_cnt_q <= '0;
            mode_q    <= 1'b0;
            cin_q     <= 1'b0;
            cmd_q     <= '0;
            inp_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            res_q     <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
            lat_cnt_q <= lat_cnt_d;
            mode_q    <= mode_d;
            cin_q     <= cin_d;
            cmd_q     <= cmd_d;
            inp_q     <= inp_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            res_q     <= res_d;
            flags_q   <= flags_d;
        end
    end

    // Grant, issue, latency wait and response hold sequencing
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        lat_cnt_d   = lat_cnt_q;
        mode_d      = mode_q;
        cin_d       = cin_q;
        cmd_d       = cmd_q;
        inp_d       = inp_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        res_d       = res_q;
        flags_d     = flags_q;
        req_ready_c = '0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    req_ready_c = grant;
                    id_d        = grant_idx;
                    mode_d      = req_mode[grant_idx];
                    cin_d       = req_cin[grant_idx];
                    cmd_d       = req_cmd[grant_idx*4 +: 4];
                    inp_d       = req_inp_vld[grant_idx*2 +: 2];
                    opa_d       = req_opa[grant_idx*DATA_W +: DATA_W];
                    opb_d       = req_opb[grant_idx*DATA_W +: DATA_W];
                    rr_ptr_d    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                lat_cnt_d = is_mul(mode_q, cmd_q) ? LAT_W'(MUL_LAT) : LAT_W'(ALU_LAT);
                state_d   = WAIT;
            end
            WAIT: begin
                lat_cnt_d = lat_cnt_q - LAT_W'(1);
                if (lat_cnt_q == LAT_W'(1)) begin
                    res_d   = alu_res;
                    flags_d = '{err: alu_err, oflow: alu_oflow, cout: alu_cout,
                                g: alu_g, l: alu_l, e: alu_e};
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset forces the accept pulse low even though the grant path is combinational
    assign req_ready   = RST ? '0 : req_ready_c;

    assign rsp_valid   = (state_q == RESP);
    assign rsp_id      = id_q;
    assign rsp_res     = res_q;
    assign rsp_flags   = flags_q;

    assign alu_ce      = (state_q == ISSUE) || (state_q == WAIT);
    assign alu_inp_vld = (state_q == ISSUE) ? inp_q : 2'b00;
    assign alu_mode    = mode_q;
    assign alu_cmd     = cmd_q;
    assign alu_cin     = cin_q;
    assign alu_opa     = opa_q;
    assign alu_opb     = opb_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// tb/tb_alu_req_scheduler.sv - scoreboard bench for alu_req_scheduler with a behavioural ALU
module tb_alu_req_scheduler;

    localparam int N       = 4;
    localparam int W       = 8;
    localparam int IDW     = 2;
    localparam int ALU_LAT = 1;
    localparam int MUL_LAT = 2;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_mode = '0;
    logic [N*4-1:0]  req_cmd = '0;
    logic [N*2-1:0]  req_inp_vld = '0;
    logic [N-1:0]    req_cin = '0;
    logic [N*W-1:0]  req_opa = '0;
    logic [N*W-1:0]  req_opb = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [IDW-1:0]  rsp_id;
    logic [W:0]      rsp_res;
    logic [5:0]      rsp_flags;
    logic            alu_ce;
    logic [1:0]      alu_inp_vld;
    logic            alu_mode;
    logic [3:0]      alu_cmd;
    logic            alu_cin;
    logic [W-1:0]    alu_opa;
    logic [W-1:0]    alu_opb;
    logic [W:0]      alu_res = '0;
    logic            alu_err = 1'b0, alu_oflow = 1'b0, alu_cout = 1'b0;
    logic            alu_g = 1'b0, alu_l = 1'b0, alu_e = 1'b0;

    alu_req_scheduler #(.NUM_REQ(N), .DATA_W(W), .ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_cmd(req_cmd),
        .req_inp_vld(req_inp_vld), .req_cin(req_cin), .req_opa(req_opa), .req_opb(req_opb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_res(rsp_res),
        .rsp_flags(rsp_flags), .alu_ce(alu_ce), .alu_inp_vld(alu_inp_vld), .alu_mode(alu_mode),
        .alu_cmd(alu_cmd), .alu_cin(alu_cin), .alu_opa(alu_opa), .alu_opb(alu_opb),
        .alu_res(alu_res), .alu_err(alu_err), .alu_oflow(alu_oflow), .alu_cout(alu_cout),
        .alu_g(alu_g), .alu_l(alu_l), .alu_e(alu_e)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural ALU: returns {res[8:0], ERR, OFLOW, COUT, G, L, E}
    function automatic logic [14:0] alu_fn(input logic mode, input logic [3:0] cmd,
                                           input logic cin, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        logic [5:0] f;
        r = '0;
        f = '0;
        if (mode) begin
            case (cmd)
                4'd0:  begin r = {1'b0, a} + {1'b0, b}; f[3] = r[8]; end
                4'd1:  begin r = {1'b0, a} - {1'b0, b}; f[4] = (a < b); end
                4'd2:  begin r = {1'b0, a} + {1'b0, b} + {8'd0, cin}; f[3] = r[8]; end
                4'd8:  begin f[2] = (a > b); f[1] = (a < b); f[0] = (a == b); end
                4'd9:  r = 9'((int'(a) + 1) * (int'(b) + 1));
                4'd10: r = 9'((int'(a) << 1) * int'(b));
                default: f[5] = 1'b1;
            endcase
        end else begin
            case (cmd)
                4'd0:    r = {1'b0, a & b};
                4'd1:    r = {1'b0, a | b};
                4'd2:    r = {1'b0, a ^ b};
                default: f[5] = 1'b1;
            endcase
        end
        return {r, f};
    endfunction

    function automatic int op_lat(input logic mode, input logic [3:0] cmd);
        return (mode && (cmd == 4'd9 || cmd == 4'd10)) ? MUL_LAT : ALU_LAT;
    endfunction

    // ALU stand-in: outputs are garbage until the command's latency has elapsed
    logic [14:0] alu_pend;
    int          alu_age = 0;
    int          alu_plat = 1;
    bit          alu_active = 0;
    always @(negedge CLK) begin
        if (RST) begin
            alu_active = 0;
        end else if (alu_ce && alu_inp_vld != 2'b00) begin
            alu_pend   = alu_fn(alu_mode, alu_cmd, alu_cin, alu_opa, alu_opb);
            alu_plat   = op_lat(alu_mode, alu_cmd);
            alu_age    = 0;
            alu_active = 1;
        end else if (alu_active) begin
            alu_age++;
        end
        if (alu_active && alu_age >= alu_plat)
            {alu_res, alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e} = alu_pend;
        else
            {alu_res, alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e} = {9'h155, 6'b101010};
    end

    typedef struct {
        int          id;
        logic [14:0] rf;
        int          t_acc;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    // Request-side reference model: round-robin pointer and busy flag in plain integers
    int           m_ptr  = 0;
    bit           m_idle = 1;
    int           m_g;
    logic [N-1:0] m_eg;
    always @(negedge CLK) begin
        if (!RST) begin
            if (m_idle) begin
                m_g = -1;
                for (int k = 0; k < N; k++)
                    if (m_g < 0 && req_valid[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
                if (m_g >= 0) begin
                    m_eg = '0;
                    m_eg[m_g] = 1'b1;
                    chk("grant", req_ready, m_eg);
                    exp_q.push_back('{id: m_g,
                        rf: alu_fn(req_mode[m_g], req_cmd[m_g*4 +: 4], req_cin[m_g],
                                   req_opa[m_g*W +: W], req_opb[m_g*W +: W]),
                        t_acc: cyc, lat: op_lat(req_mode[m_g], req_cmd[m_g*4 +: 4])});
                    m_ptr  = (m_g + 1) % N;
                    m_idle = 0;
                end else begin
                    chk("no_grant_idle", req_ready, '0);
                end
            end else begin
                chk("no_grant_busy", req_ready, '0);
            end
            if (rsp_valid && rsp_ready) m_idle = 1;
        end
    end

    // Response monitor: pops the scoreboard on each new response, then checks it holds
    bit          in_rsp = 0;
    exp_t        m_e;
    logic [16:0] m_hold;
    always @(negedge CLK) begin
        if (!RST && rsp_valid) begin
            if (!in_rsp) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got id=%0d res=%0h, expected no response", rsp_id, rsp_res);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("rsp_id", rsp_id, m_e.id);
                    chk("rsp_res", rsp_res, m_e.rf[14:6]);
                    chk("rsp_flags", rsp_flags, m_e.rf[5:0]);
                    chk("rsp_latency", cyc - m_e.t_acc, 2 + m_e.lat);
                end
                m_hold = {rsp_id, rsp_res, rsp_flags};
                in_rsp = 1;
            end else begin
                chk("rsp_stable", {rsp_id, rsp_res, rsp_flags}, m_hold);
            end
            if (rsp_ready) in_rsp = 0;
        end
    end

    function automatic logic [63:0] all_out();
        return {req_ready, rsp_valid, rsp_id, rsp_res, rsp_flags, alu_ce, alu_inp_vld,
                alu_mode, alu_cmd, alu_cin, alu_opa, alu_opb};
    endfunction

    task automatic set_req(input int id, input logic mode, input logic [3:0] cmd,
                           input logic cin, input logic [7:0] a, input logic [7:0] b);
        req_mode[id]          = mode;
        req_cmd[id*4 +: 4]    = cmd;
        req_inp_vld[id*2 +: 2] = 2'b11;
        req_cin[id]           = cin;
        req_opa[id*W +: W]    = a;
        req_opb[id*W +: W]    = b;
    endtask

    task automatic issue(input int id, input logic mode, input logic [3:0] cmd,
                         input logic cin, input logic [7:0] a, input logic [7:0] b);
        bit got;
        got = 0;
        req_valid = '0;
        set_req(id, mode, cmd, cin, a, b);
        req_valid[id] = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge CLK);
            if (req_ready[id]) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: requester %0d not granted within 50 cycles", id);
        end
        @(posedge CLK);
        #1 req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(output logic [IDW-1:0] id, output logic [8:0] res, output logic [5:0] fl);
        bit got;
        got = 0;
        id = '0; res = '0; fl = '0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge CLK);
            if (rsp_valid && rsp_ready) begin
                got = 1;
                id = rsp_id; res = rsp_res; fl = rsp_flags;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: no response handshake within 50 cycles");
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && !rsp_valid) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
        end
        @(posedge CLK);
        #1;
    endtask

    logic [IDW-1:0] r_id;
    logic [8:0]     r_res;
    logic [5:0]     r_fl;

    initial begin
        #12 chk("reset_outputs", all_out(), '0);
        #11 RST = 1'b0;

        // Round-robin with everyone requesting: 0,1,2,3,0
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 4'd0, 1'b0, 8'(i * 3), 8'(i + 7));
        @(posedge CLK);
        #1 req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            bit got;
            int gi;
            got = 0;
            gi  = -1;
            for (int t = 0; t < 50 && !got; t++) begin
                @(negedge CLK);
                if (req_ready != '0) begin
                    got = 1;
                    for (int i = 0; i < N; i++) if (req_ready[i]) gi = i;
                end
            end
            chk("rr_order", gi, k % N);
            @(posedge CLK);
        end
        #1 req_valid = '0;
        drain();

        // Single ADD on requester 0
        issue(0, 1'b1, 4'd0, 1'b0, 8'd10, 8'd20);
        wait_rsp(r_id, r_res, r_fl);
        chk("add_id", r_id, 0);
        chk("add_res", r_res, 30);
        chk("add_err", r_fl[5], 0);

        // Multiply on requester 1: (3+1)*(4+1)
        issue(1, 1'b1, 4'd9, 1'b0, 8'd3, 8'd4);
        wait_rsp(r_id, r_res, r_fl);
        chk("mul_id", r_id, 1);
        chk("mul_res", r_res, 20);

        // Compare equal operands
        issue(2, 1'b1, 4'd8, 1'b0, 8'd5, 8'd5);
        wait_rsp(r_id, r_res, r_fl);
        chk("cmp_res", r_res, 0);
        chk("cmp_gle", r_fl[2:0], 3'b001);

        // Backpressure: response held 5 cycles while requester 0 waits
        rsp_ready = 1'b0;
        issue(3, 1'b1, 4'd0, 1'b0, 8'd7, 8'd8);
        set_req(0, 1'b0, 4'd2, 1'b0, 8'hF0, 8'h3C);
        req_valid[0] = 1'b1;
        begin
            bit got;
            got = 0;
            for (int t = 0; t < 50 && !got; t++) begin
                @(negedge CLK);
                if (rsp_valid) got = 1;
            end
            chk("bp_rsp_seen", got, 1);
        end
        repeat (5) @(negedge CLK);
        chk("bp_res_held", {rsp_valid, rsp_id, rsp_res}, {1'b1, 2'd3, 9'd15});
        @(posedge CLK);
        #1 rsp_ready = 1'b1;
        @(negedge CLK);
        chk("bp_no_grant_hs", req_ready, '0);
        @(negedge CLK);
        chk("bp_grant_after_hs", req_ready, 4'b0001);
        @(posedge CLK);
        #1 req_valid = '0;
        drain();

        // Randomized traffic with random backpressure and changing fields
        for (int c = 0; c < 1500; c++) begin
            req_valid   = N'($urandom);
            req_mode    = N'($urandom);
            req_cin     = N'($urandom);
            req_opa     = (N*W)'({$urandom, $urandom});
            req_opb     = (N*W)'({$urandom, $urandom});
            for (int i = 0; i < N; i++) begin
                req_cmd[i*4 +: 4]     = ($urandom_range(0, 3) == 0) ? 4'(8 + $urandom_range(0, 2))
                                                                    : 4'($urandom_range(0, 15));
                req_inp_vld[i*2 +: 2] = 2'($urandom_range(1, 3));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge CLK);
            #1;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        drain();

        // Reset in the middle of a multiply wait, then check the pointer restarts at 0
        issue(2, 1'b1, 4'd9, 1'b0, 8'd9, 8'd9);
        @(posedge CLK);
        #3 RST = 1'b1;
        #1 chk("midreset_outputs", all_out(), '0);
        exp_q.delete();
        m_ptr  = 0;
        m_idle = 1;
        in_rsp = 0;
        @(posedge CLK);
        @(posedge CLK);
        #3 RST = 1'b0;
        set_req(2, 1'b1, 4'd0, 1'b0, 8'd1, 8'd2);
        set_req(3, 1'b1, 4'd0, 1'b0, 8'd3, 8'd4);
        req_valid = 4'b1100;
        @(negedge CLK);
        chk("post_reset_grant", req_ready, 4'b0100);
        @(posedge CLK);
        #1 req_valid = '0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
